// File: rtl/pdp_cu_pkg.sv
// pdp_cu_pkg: shared definitions for the PDP-style multicycle control unit.
//   cu_state_e  - control-unit state encoding (also exported on state_o)
//   OP_*        - IR opcode values
//   MSRC_*      - memory address mux selects
//   PCSRC_*     - PC load source selects
//   ALU_*       - ALU function selects
//   SRCB_*      - ALU B-operand selects
//   dispatch()  - post-address-resolution routing by opcode
package pdp_cu_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_IND      = 4'd2,
        ST_EXEC_RD  = 4'd3,
        ST_EXEC_WR  = 4'd4,
        ST_ISZ_WB   = 4'd5,
        ST_OPR      = 4'd6,
        ST_HALT     = 4'd7,
        ST_FAULT    = 4'd8,
        ST_IRQ_SAVE = 4'd9
    } cu_state_e;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STA = 3'b011;
    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_JSR = 3'b101;
    localparam logic [2:0] OP_ISZ = 3'b110;
    localparam logic [2:0] OP_OPR = 3'b111;

    localparam logic [1:0] MSRC_PC = 2'b00;
    localparam logic [1:0] MSRC_EA = 2'b01;
    localparam logic [1:0] MSRC_IR = 2'b10;

    localparam logic [1:0] PCSRC_INC = 2'b00;
    localparam logic [1:0] PCSRC_EA  = 2'b01;
    localparam logic [1:0] PCSRC_EA1 = 2'b10;

    localparam logic [1:0] ALU_PASSB = 2'b00;
    localparam logic [1:0] ALU_AND   = 2'b01;
    localparam logic [1:0] ALU_ADD   = 2'b10;
    localparam logic [1:0] ALU_INC   = 2'b11;

    localparam logic [1:0] SRCB_MDR  = 2'b00;
    localparam logic [1:0] SRCB_ZERO = 2'b01;
    localparam logic [1:0] SRCB_ONE  = 2'b10;

    // Where an instruction goes once its effective address is final.
    // ST_FETCH means the instruction completes here (JMP).
    function automatic cu_state_e dispatch(input logic [2:0] op);
        case (op)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: dispatch = ST_EXEC_RD;
            OP_STA, OP_JSR:                 dispatch = ST_EXEC_WR;
            OP_JMP:                         dispatch = ST_FETCH;
            default:                        dispatch = ST_OPR;
        endcase
    endfunction

endpackage

// File: rtl/pdp_cu_wait.sv
// pdp_cu_wait: memory handshake helper for the control unit.
//   req       in  state wants a memory access
//   clr       in  restart the wait count (state change or completed access)
//   mem_ready in  memory completes the current request
//   mem_req   out request strobe; dropped asynchronously by reset
//   done      out request accepted this cycle
//   timeout   out TMO_MAX wait cycles elapsed and memory still not ready
module pdp_cu_wait #(
    parameter int unsigned TMO_W   = 4,
    parameter int unsigned TMO_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic clr,
    input  logic mem_ready,
    output logic mem_req,
    output logic done,
    output logic timeout
);

    logic [TMO_W-1:0] wait_cnt;
    logic             stall;

    // Gating with rst_n keeps a reset mid-access from leaving a strobe up
    // while the state register is being forced back to FETCH.
    assign mem_req = req & rst_n;
    assign done    = mem_req & mem_ready;
    assign stall   = mem_req & ~mem_ready;
    assign timeout = stall & (wait_cnt == TMO_W'(TMO_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (stall) begin
            wait_cnt <= wait_cnt + TMO_W'(1);
        end
    end

endmodule

// File: rtl/pdp_cu_hs.sv
// pdp_cu_hs: multicycle control unit with memory request/ready handshake,
// timeout, bounded multi-level indirection, ISZ/JSR sequencing and a
// sticky HALT/FAULT terminal state.
//   clk, rst_n            clock, async active-low reset
//   op, ind, opr_hlt      IR opcode, indirect bit, OPR halt microbit
//   skip_cond             datapath zero flag
//   mem_ready/mem_req/mem_we/mem_src   memory handshake and address select
//   ldir..ldcy            register load enables
//   pcsrc, alu_fnc, alu_srca, alu_srcb, wr_src   datapath selects
//   busy, fault, state_o  status and debug state
// Optional: define CU_IRQ_EN to add irq/ien inputs and the IRQ_SAVE state.
module pdp_cu_hs
    import pdp_cu_pkg::*;
#(
    parameter int unsigned IND_DEPTH = 1,
    parameter int unsigned TMO_W     = 4,
    parameter int unsigned TMO_MAX   = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] op,
    input  logic       ind,
    input  logic       opr_hlt,
    input  logic       skip_cond,
    input  logic       mem_ready,
`ifdef CU_IRQ_EN
    input  logic       irq,
    input  logic       ien,
`endif
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] mem_src,
    output logic       ldir,
    output logic       ldea,
    output logic       ldpc,
    output logic       ldacc,
    output logic       ldcy,
    output logic [1:0] pcsrc,
    output logic [1:0] alu_fnc,
    output logic       alu_srca,
    output logic [1:0] alu_srcb,
    output logic       wr_src,
    output logic       busy,
    output logic       fault,
    output logic [3:0] state_o
);

    localparam int unsigned IW = $clog2(IND_DEPTH + 1);

    cu_state_e     state, state_nxt, fetch_nxt, disp;
    logic [IW-1:0] ind_cnt;
    logic          ind_inc, end_instr, req, done, timeout, clr;

    assign clr     = (state_nxt != state) | done;
    assign fault   = (state == ST_FAULT);
    assign state_o = state;

    pdp_cu_wait #(
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) u_wait (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .clr       (clr),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .done      (done),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Indirection levels taken by the current instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ind_cnt <= '0;
        end else if (state == ST_FETCH) begin
            ind_cnt <= '0;
        end else if (ind_inc) begin
            ind_cnt <= ind_cnt + IW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        mem_we    = 1'b0;
        mem_src   = MSRC_PC;
        ldir      = 1'b0;
        ldea      = 1'b0;
        ldpc      = 1'b0;
        ldacc     = 1'b0;
        ldcy      = 1'b0;
        pcsrc     = PCSRC_INC;
        alu_fnc   = ALU_PASSB;
        alu_srca  = 1'b0;
        alu_srcb  = SRCB_MDR;
        wr_src    = 1'b0;
        busy      = 1'b1;
        ind_inc   = 1'b0;
        end_instr = 1'b0;
        disp      = dispatch(op);
        fetch_nxt = ST_FETCH;
`ifdef CU_IRQ_EN
        if (irq && ien) fetch_nxt = ST_IRQ_SAVE;
`endif

        case (state)
            ST_FETCH: begin
                req = 1'b1;
                if (done) begin
                    ldir      = 1'b1;
                    ldpc      = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ldea    = 1'b1;
                mem_src = MSRC_IR;
                if (ind) begin
                    state_nxt = ST_IND;
                end else if (disp == ST_FETCH) begin
                    ldpc      = 1'b1;
                    pcsrc     = PCSRC_EA;
                    end_instr = 1'b1;
                end else begin
                    state_nxt = disp;
                end
            end
            ST_IND: begin
                // ind here is the indirect bit of the pointer word just read;
                // set means another level is wanted.
                req     = 1'b1;
                mem_src = MSRC_EA;
                if (done) begin
                    ldea    = 1'b1;
                    ind_inc = 1'b1;
                    if (ind) begin
                        state_nxt = (ind_cnt == IW'(IND_DEPTH - 1)) ? ST_FAULT : ST_IND;
                    end else if (disp == ST_FETCH) begin
                        ldpc      = 1'b1;
                        pcsrc     = PCSRC_EA;
                        end_instr = 1'b1;
                    end else begin
                        state_nxt = disp;
                    end
                end
            end
            ST_EXEC_RD: begin
                req     = 1'b1;
                mem_src = MSRC_EA;
                case (op)
                    OP_AND:  alu_fnc = ALU_AND;
                    OP_ADD:  alu_fnc = ALU_ADD;
                    default: alu_fnc = ALU_PASSB;
                endcase
                if (done) begin
                    ldacc = (op == OP_AND) | (op == OP_ADD) | (op == OP_LDA);
                    ldcy  = (op == OP_ADD);
                    if (op == OP_ISZ) state_nxt = ST_ISZ_WB;
                    else              end_instr = 1'b1;
                end
            end
            ST_ISZ_WB: begin
                req     = 1'b1;
                mem_we  = 1'b1;
                mem_src = MSRC_EA;
                alu_fnc = ALU_INC;
                wr_src  = 1'b1;
                if (done) begin
                    ldpc      = skip_cond;
                    end_instr = 1'b1;
                end
            end
            ST_EXEC_WR: begin
                req      = 1'b1;
                mem_we   = 1'b1;
                mem_src  = MSRC_EA;
                wr_src   = (op == OP_JSR);
                alu_srca = (op == OP_JSR);
                if (done) begin
                    if (op == OP_JSR) begin
                        ldpc  = 1'b1;
                        pcsrc = PCSRC_EA1;
                    end
                    end_instr = 1'b1;
                end
            end
            ST_OPR: begin
                if (opr_hlt) begin
                    state_nxt = ST_HALT;
                end else begin
                    ldpc      = skip_cond;
                    end_instr = 1'b1;
                end
            end
            ST_HALT: begin
                busy = 1'b0;
            end
            ST_FAULT: begin
                busy = 1'b0;
            end
`ifdef CU_IRQ_EN
            ST_IRQ_SAVE: begin
                // IR (and hence the page address and EA) is cleared by the
                // datapath on interrupt entry, so the write lands at 0 and
                // EA+1 reloads PC with 1.
                req      = 1'b1;
                mem_we   = 1'b1;
                mem_src  = MSRC_IR;
                wr_src   = 1'b1;
                alu_srca = 1'b1;
                if (done) begin
                    ldpc      = 1'b1;
                    pcsrc     = PCSRC_EA1;
                    state_nxt = ST_FETCH;
                end
            end
`endif
            default: begin
                state_nxt = ST_FAULT;
            end
        endcase

        if (end_instr) state_nxt = fetch_nxt;
        if (timeout)   state_nxt = ST_FAULT;
    end

endmodule
